// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin byte arbiter slice.
// Owns the FSM encoding and the channel geometry (8 requesters, 3-bit select, byte data).
package rr_mux_arbiter_pkg;

  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/consumer bundle of the arbiter: request side (req/last/data_in/gnt)
// and the registered valid/ready output side (out_*).
interface rr_mux_arbiter_if
  import rr_mux_arbiter_pkg::*;
();

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        last;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic [N_REQ-1:0]        gnt;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_ready;

  // Requesters plus downstream consumer.
  modport master (
    output req, last, data_in, out_ready,
    input  gnt, out_sel, out_valid, out_data
  );

  // The arbiter itself.
  modport slave (
    input  req, last, data_in, out_ready,
    output gnt, out_sel, out_valid, out_data
  );

endinterface

// File: rtl/mux8to1.sv
// Generic 8:1 byte multiplexer shared across the codebase.
// Purely combinational; Sel picks one of In0..In7.
module mux8to1 (
  input  logic [2:0] Sel,
  input  logic [7:0] In0,
  input  logic [7:0] In1,
  input  logic [7:0] In2,
  input  logic [7:0] In3,
  input  logic [7:0] In4,
  input  logic [7:0] In5,
  input  logic [7:0] In6,
  input  logic [7:0] In7,
  output logic [7:0] Out
);

  always_comb begin
    case (Sel)
      3'd1:    Out = In1;
      3'd2:    Out = In2;
      3'd3:    Out = In3;
      3'd4:    Out = In4;
      3'd5:    Out = In5;
      3'd6:    Out = In6;
      3'd7:    Out = In7;
      default: Out = In0;
    endcase
  end

endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority picker: returns the first set req bit at or after ptr
// (searching ptr, ptr+1, ... modulo 8) and whether any request is present.
module rr_pick8
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered byte channel among 8 requesters.
// One owner per burst; bursts end on last or after MAX_BEATS beats.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int MAX_BEATS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_mux_arbiter_if.slave    bus
);

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  owner_q, owner_d;
  logic [7:0]        beat_q, beat_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [N_REQ-1:0]  gnt_d;
  logic              accept;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] mux_out;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The select is the registered owner, so it never changes inside a burst.
  mux8to1 u_mux (
    .Sel (owner_q),
    .In0 (bus.data_in[ 7: 0]),
    .In1 (bus.data_in[15: 8]),
    .In2 (bus.data_in[23:16]),
    .In3 (bus.data_in[31:24]),
    .In4 (bus.data_in[39:32]),
    .In5 (bus.data_in[47:40]),
    .In6 (bus.data_in[55:48]),
    .In7 (bus.data_in[63:56]),
    .Out (mux_out)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    valid_d = valid_q && !bus.out_ready;
    data_d  = data_q;
    gnt_d   = '0;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          beat_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A beat moves only if the output register is empty or draining now.
        accept = bus.req[owner_q] && (!valid_q || bus.out_ready);
        if (accept) begin
          gnt_d   = N_REQ'(1) << owner_q;
          data_d  = mux_out;
          valid_d = 1'b1;
          beat_d  = beat_q + 8'd1;
          if (bus.last[owner_q] || (beat_q == LAST_BEAT)) begin
            ptr_d   = owner_q + SEL_W'(1);
            beat_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.gnt       = gnt_d;
  assign bus.out_sel   = owner_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: inputs change on the falling edge,
// outputs are compared 1 ns later against hand-computed expectations.
module tb_rr_mux_arbiter;

  localparam logic [63:0] BASE = 64'hF7E6_D5C4_B3A5_9180;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  rr_mux_arbiter_if bus ();

  rr_mux_arbiter #(.MAX_BEATS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect4(input string tag, input logic [7:0] g, input logic v,
                         input logic [7:0] d, input logic [2:0] s);
    check({tag, ".gnt"},       64'(bus.gnt),       64'(g));
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(v));
    check({tag, ".out_data"},  64'(bus.out_data),  64'(d));
    check({tag, ".out_sel"},   64'(bus.out_sel),   64'(s));
  endtask

  // Drive one cycle's inputs at the falling edge; they are consumed at the next rising edge.
  task automatic step(input logic [7:0] r, input logic [7:0] l, input logic rdy,
                      input logic [63:0] d);
    @(negedge clk);
    bus.req       = r;
    bus.last      = l;
    bus.out_ready = rdy;
    bus.data_in   = d;
    #1;
  endtask

  function automatic logic [63:0] with_b5(input logic [7:0] b);
    logic [63:0] v;
    v = BASE;
    v[47:40] = b;
    return v;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    bus.req       = '0;
    bus.last      = '0;
    bus.data_in   = BASE;
    bus.out_ready = 1'b1;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1 expect4("por", 8'h00, 1'b0, 8'h00, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h00, 8'h00, 1'b1, BASE); expect4("idle0", 8'h00, 1'b0, 8'h00, 3'd0);
    step(8'h00, 8'h00, 1'b1, BASE); expect4("idle1", 8'h00, 1'b0, 8'h00, 3'd0);

    // Single beat from requester 2, then ptr=3 picks 3 over 0, then 0
    step(8'h04, 8'h04, 1'b1, BASE); expect4("sb1", 8'h00, 1'b0, 8'h00, 3'd0);
    step(8'h04, 8'h04, 1'b1, BASE); expect4("sb2", 8'h04, 1'b0, 8'h00, 3'd2);
    step(8'h09, 8'h09, 1'b1, BASE); expect4("sb3", 8'h00, 1'b1, 8'hA5, 3'd2);
    step(8'h09, 8'h09, 1'b1, BASE); expect4("sb4", 8'h08, 1'b0, 8'hA5, 3'd3);
    step(8'h01, 8'h01, 1'b1, BASE); expect4("sb5", 8'h00, 1'b1, 8'hB3, 3'd3);
    step(8'h01, 8'h01, 1'b1, BASE); expect4("sb6", 8'h01, 1'b0, 8'hB3, 3'd0);
    step(8'h00, 8'h00, 1'b1, BASE); expect4("sb7", 8'h00, 1'b1, 8'h80, 3'd0);

    // Asynchronous reset mid-burst with out_valid=1
    step(8'h20, 8'h00, 1'b1, BASE); expect4("rs1", 8'h00, 1'b0, 8'h80, 3'd0);
    step(8'h20, 8'h00, 1'b1, BASE); expect4("rs2", 8'h20, 1'b0, 8'h80, 3'd5);
    step(8'h20, 8'h00, 1'b1, BASE); expect4("rs3", 8'h20, 1'b1, 8'hD5, 3'd5);
    #1 rst_n = 1'b0;
    #1 expect4("rs_async", 8'h00, 1'b0, 8'h00, 3'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    bus.req  = '0;
    bus.last = '0;
    #1 expect4("rs_rel", 8'h00, 1'b0, 8'h00, 3'd0);
    step(8'h00, 8'h00, 1'b1, BASE); expect4("rs_idle", 8'h00, 1'b0, 8'h00, 3'd0);

    // Round robin between 0 and 7 from ptr=0, then 6 moves ptr to 7
    step(8'h81, 8'h81, 1'b1, BASE); expect4("rr1",  8'h00, 1'b0, 8'h00, 3'd0);
    step(8'h81, 8'h81, 1'b1, BASE); expect4("rr2",  8'h01, 1'b0, 8'h00, 3'd0);
    step(8'h81, 8'h81, 1'b1, BASE); expect4("rr3",  8'h00, 1'b1, 8'h80, 3'd0);
    step(8'h81, 8'h81, 1'b1, BASE); expect4("rr4",  8'h80, 1'b0, 8'h80, 3'd7);
    step(8'h81, 8'h81, 1'b1, BASE); expect4("rr5",  8'h00, 1'b1, 8'hF7, 3'd7);
    step(8'h81, 8'h81, 1'b1, BASE); expect4("rr6",  8'h01, 1'b0, 8'hF7, 3'd0);
    step(8'h81, 8'h81, 1'b1, BASE); expect4("rr7",  8'h00, 1'b1, 8'h80, 3'd0);
    step(8'h81, 8'h81, 1'b1, BASE); expect4("rr8",  8'h80, 1'b0, 8'h80, 3'd7);
    step(8'h40, 8'h40, 1'b1, BASE); expect4("rr9",  8'h00, 1'b1, 8'hF7, 3'd7);
    step(8'h40, 8'h40, 1'b1, BASE); expect4("rr10", 8'h40, 1'b0, 8'hF7, 3'd6);
    step(8'h81, 8'h81, 1'b1, BASE); expect4("rr11", 8'h00, 1'b1, 8'hE6, 3'd6);
    step(8'h81, 8'h81, 1'b1, BASE); expect4("rr12", 8'h80, 1'b0, 8'hE6, 3'd7);
    step(8'h00, 8'h00, 1'b1, BASE); expect4("rr13", 8'h00, 1'b1, 8'hF7, 3'd7);

    // Backpressure: 4-beat burst from requester 5 with bytes 51..54
    step(8'h20, 8'h00, 1'b1, with_b5(8'h51)); expect4("bp1",  8'h00, 1'b0, 8'hF7, 3'd7);
    step(8'h20, 8'h00, 1'b0, with_b5(8'h51)); expect4("bp2",  8'h20, 1'b0, 8'hF7, 3'd5);
    step(8'h20, 8'h00, 1'b0, with_b5(8'h52)); expect4("bp3",  8'h00, 1'b1, 8'h51, 3'd5);
    step(8'h20, 8'h00, 1'b1, with_b5(8'h52)); expect4("bp4",  8'h20, 1'b1, 8'h51, 3'd5);
    step(8'h20, 8'h00, 1'b0, with_b5(8'h53)); expect4("bp5",  8'h00, 1'b1, 8'h52, 3'd5);
    step(8'h20, 8'h00, 1'b0, with_b5(8'h53)); expect4("bp6",  8'h00, 1'b1, 8'h52, 3'd5);
    step(8'h20, 8'h00, 1'b1, with_b5(8'h53)); expect4("bp7",  8'h20, 1'b1, 8'h52, 3'd5);
    step(8'h20, 8'h20, 1'b0, with_b5(8'h54)); expect4("bp8",  8'h00, 1'b1, 8'h53, 3'd5);
    step(8'h20, 8'h20, 1'b1, with_b5(8'h54)); expect4("bp9",  8'h20, 1'b1, 8'h53, 3'd5);
    step(8'h00, 8'h00, 1'b0, with_b5(8'h54)); expect4("bp10", 8'h00, 1'b1, 8'h54, 3'd5);
    step(8'h00, 8'h00, 1'b1, with_b5(8'h54)); expect4("bp11", 8'h00, 1'b1, 8'h54, 3'd5);
    step(8'h00, 8'h00, 1'b1, BASE);           expect4("bp12", 8'h00, 1'b0, 8'h54, 3'd5);

    // MAX_BEATS cap: requester 1 never sends last, requester 3 waits
    step(8'h0A, 8'h08, 1'b1, BASE); expect4("cap0", 8'h00, 1'b0, 8'h54, 3'd5);
    for (int k = 0; k < 16; k++) begin
      step(8'h0A, 8'h08, 1'b1, BASE);
      expect4($sformatf("cap_beat%0d", k), 8'h02, (k != 0), (k == 0) ? 8'h54 : 8'h91, 3'd1);
    end
    step(8'h0A, 8'h08, 1'b1, BASE); expect4("cap_idle", 8'h00, 1'b1, 8'h91, 3'd1);
    step(8'h0A, 8'h08, 1'b1, BASE); expect4("cap_next", 8'h08, 1'b0, 8'h91, 3'd3);
    step(8'h00, 8'h00, 1'b1, BASE); expect4("cap_done", 8'h00, 1'b1, 8'hB3, 3'd3);

    // Owner stall: owner 6 drops req for 3 cycles while requester 0 waits
    step(8'h41, 8'h01, 1'b1, BASE); expect4("st1", 8'h00, 1'b0, 8'hB3, 3'd3);
    step(8'h41, 8'h01, 1'b1, BASE); expect4("st2", 8'h40, 1'b0, 8'hB3, 3'd6);
    step(8'h01, 8'h01, 1'b1, BASE); expect4("st3", 8'h00, 1'b1, 8'hE6, 3'd6);
    step(8'h01, 8'h01, 1'b1, BASE); expect4("st4", 8'h00, 1'b0, 8'hE6, 3'd6);
    step(8'h01, 8'h01, 1'b1, BASE); expect4("st5", 8'h00, 1'b0, 8'hE6, 3'd6);
    step(8'h41, 8'h41, 1'b1, BASE); expect4("st6", 8'h40, 1'b0, 8'hE6, 3'd6);
    step(8'h01, 8'h01, 1'b1, BASE); expect4("st7", 8'h00, 1'b1, 8'hE6, 3'd6);
    step(8'h01, 8'h01, 1'b1, BASE); expect4("st8", 8'h01, 1'b0, 8'hE6, 3'd0);
    step(8'h00, 8'h00, 1'b1, BASE); expect4("st9", 8'h00, 1'b1, 8'h80, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit output channel among 8 requesters.
- Grants one owner for a burst, drives the 3-bit select of an 8:1 8-bit data mux, and registers the selected byte into a valid/ready output stage.
- Sits between peripheral/bus byte sources and a single downstream consumer (e.g. a UART TX or debug port).

Parameters:
- MAX_BEATS, 16, maximum beats per grant before a forced release (fairness cap), range 1..256.
- N_REQ, 8, number of requesters; fixed at 8 because the select is 3 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  per-requester beat request; bit i belongs to requester i.
- last  input  8  per-requester end-of-burst flag, qualified by req[i].
- data_in  input  64  packed requester bytes; requester i is bits [8i+7:8i].
- gnt  output  8  one-hot, 1-cycle pulse: the beat of requester i is accepted this cycle.
- out_sel  output  3  current owner index; drives the mux select.
- out_valid  output  1  registered output byte is valid.
- out_data  output  8  registered output byte.
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0, owner=0, beat_cnt=0, out_valid=0, out_data=8'h00, out_sel=3'd0, gnt=8'h00.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise owner = first i with req[i]=1, searching ptr, ptr+1, ..., ptr+7 (mod 8).
  - Go to BUSY with beat_cnt=0. No gnt is issued in the IDLE cycle.
- State BUSY:
  - accept = req[owner] && (!out_valid || out_ready).
  - On accept: gnt[owner]=1 for that cycle, out_data <= data_in[owner], out_valid <= 1, beat_cnt++.
  - End of burst when accept && (last[owner] || beat_cnt==MAX_BEATS-1). On end: ptr <= owner+1 (mod 8), go to IDLE, beat_cnt <= 0.
  - If req[owner]=0, hold BUSY and owner with no beat; other requesters wait. Requesters must not drop req mid-burst.
- Output stage:
  - out_valid clears on out_ready when no new beat is accepted that cycle.
  - Accept while out_valid && out_ready is a simultaneous drain and load; out_valid stays 1.
  - out_data and out_valid hold while out_valid && !out_ready.
- out_sel equals owner in BUSY and holds the last owner in IDLE (mux select stays stable; no glitching).
- Latency:
  - req asserted in IDLE -> first gnt 1 cycle later.
  - gnt -> out_valid the next cycle.
  - One idle cycle between consecutive bursts.
- Throughput: 1 beat/cycle inside a burst while out_ready=1.
- Requester contract: hold req, last and data stable until its gnt pulse.
- ptr wrap: owner 7 -> ptr 0.
- Only one gnt bit is ever high.
- Reset mid-burst: immediate return to reset values; the in-flight out_data is discarded.

Decomposition:
- Shared package:
  - IDLE/BUSY state encoding.
  - N_REQ=8 and SEL_W=3 constants.
  - Byte width constant DATA_W=8.
- Sub-modules:
  - Data selection instantiates the team's existing 8:1 8-bit mux (mux8to1), with Sel=out_sel and In0..In7 taken from data_in slices.
  - The rotating priority pick is a natural small sub-module, rr_pick8: inputs req[7:0] and ptr[2:0]; outputs idx[2:0] and any.

Test Plan:
- Reset: rst_n=0 mid-burst with out_valid=1 -> all outputs zero immediately, without waiting for a clk edge. After release with req=0, outputs stay idle.
- Single beat: req=8'h04, last=8'h04, data_in byte2=8'hA5, out_ready=1 -> gnt=8'h04 at cycle 1, out_valid=1 with out_data=8'hA5 at cycle 2, out_sel=2, ptr becomes 3.
- Round robin:
  - req=8'h81 held; each burst is a single beat with last=1.
  - From ptr=0 the grants alternate 0,7,0,7.
  - Then from ptr=7, req=8'h81 grants 7 before 0.
- Backpressure:
  - Burst of 4 from requester 5 with out_ready toggling 1,0,0,1,...
  - gnt pulses only when the output is free or draining.
  - out_data holds during stall; bytes arrive in order; no loss or duplication.
- MAX_BEATS cap: MAX_BEATS=16, requester 1 holds req with last=0 -> release after the 16th gnt; one IDLE cycle; a pending requester 3 is granted next.
- Owner stall: owner 6 drops req for 3 cycles mid-burst while req[0]=1 -> no gnt during the gap, owner stays 6, and the burst resumes when req[6] returns.
